branch_outcome_predictor: RTL and testbench
===========================================

Name: branch_outcome_predictor

Overview:
- Consumer of the ALU branch result (Branch_Enable) and producer of early taken/not-taken predictions for the fetch stage.
- Holds a table of 2-bit saturating counters, indexed by branch PC.
- Predicts at decode; trains when the ALU resolves the branch.
- Raises a one-cycle mispredict pulse with the corrected PC, which the core uses to flush and redirect fetch.

Parameters:
- INDEX_BITS, 4, log2 of table entries (default 16 counters)
- ADDR_WIDTH, 32, PC / target width

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous reset, active-high
- predict_valid  input  1  decode stage presents a conditional branch this cycle
- predict_addr  input  ADDR_WIDTH  PC of the branch being predicted
- predict_offset  input  ADDR_WIDTH  sign-extended B-type immediate
- prediction_valid  output  1  registered; prediction outputs valid this cycle
- prediction_taken  output  1  registered; counter MSB at lookup time
- predicted_target  output  ADDR_WIDTH  registered; predict_addr + predict_offset
- resolve_valid  input  1  ALU resolves a branch this cycle
- resolve_addr  input  ADDR_WIDTH  PC of the resolving branch
- resolve_target  input  ADDR_WIDTH  computed branch target
- resolve_taken  input  1  actual outcome (ALU Branch_Enable)
- resolve_predicted  input  1  prediction_taken carried down the pipe with this branch
- mispredict  output  1  registered one-cycle pulse on outcome mismatch
- redirect_pc  output  ADDR_WIDTH  registered corrected fetch PC, valid when mispredict=1

Behaviour:
- Reset (async, rst=1):
  - All 2^INDEX_BITS counters set to 2'b01 (weakly not-taken).
  - prediction_valid, prediction_taken, mispredict = 0.
  - predicted_target, redirect_pc = 0.
  - Asserting rst mid-operation drops any pending pulse immediately; state is held until rst deasserts.
- Index:
  - idx = addr[INDEX_BITS+1:2]; addr[1:0] ignored.
  - Aliasing between PCs sharing an index is permitted and not detected.
- Prediction path, latency 1 cycle:
  - On the edge where predict_valid=1: prediction_valid<=1, prediction_taken<=counter[idx][1], predicted_target<=predict_addr+predict_offset.
  - Target addition is modulo 2^ADDR_WIDTH; carry is discarded.
  - When predict_valid=0: prediction_valid<=0 and the other prediction outputs hold their last values.
- Update path, on the edge where resolve_valid=1:
  - resolve_taken=1: counter increments, saturating at 2'b11.
  - resolve_taken=0: counter decrements, saturating at 2'b00.
  - Counter sequence: 00 strongly-NT, 01 weakly-NT, 10 weakly-T, 11 strongly-T.
- Mispredict path, latency 1 cycle from resolve:
  - mispredict <= resolve_valid & (resolve_taken != resolve_predicted).
  - On mismatch: redirect_pc <= resolve_taken ? resolve_target : resolve_addr+4, modulo 2^ADDR_WIDTH.
  - When there is no mismatch, redirect_pc holds its value.
  - mispredict is high for exactly one cycle per mismatching resolve. Back-to-back mismatching resolves give back-to-back pulses, each with its own redirect_pc.
- Simultaneous predict and resolve, same idx:
  - Read-before-write: the prediction uses the pre-update counter value.
  - The update still commits on the same edge.
- Simultaneous predict and resolve, different idx: both proceed independently.
- No stall or backpressure: one prediction and one update are accepted per cycle. The block never blocks.
- Storage: counter table in flops or distributed RAM, with a single combinational read port and a single write port.

Test Plan:
- Reset, then predict_addr=0x100 -> next cycle prediction_valid=1, prediction_taken=0; with predict_offset=0xFFFFFFF0, predicted_target=0x000000F0.
- Three resolves at 0x100, taken=1, predicted=0 -> mispredict pulses each cycle with redirect_pc=resolve_target. Counter path 01->10->11->11. A subsequent predict at 0x100 gives taken=1.
- From 11, four not-taken resolves -> counter 10,01,00,00 (saturates). predict gives taken=0. mispredict only on resolves where resolve_predicted=1.
- Same-cycle predict and resolve at 0x200, counter=01, resolve_taken=1 -> prediction_taken=0 (old value). A following predict gives taken=1.
- Not-taken mispredict: resolve_addr=0xFFFFFFFC, taken=0, predicted=1 -> redirect_pc=0x00000000 (wrap).
- Aliasing and reset: 0x104 and 0x144 (INDEX_BITS=4) share a counter, so training one flips the other. Asserting rst mid-pulse -> mispredict=0 immediately and all counters read 01 afterward.

Source files
------------

// File: rtl/branch_outcome_predictor.sv
// Branch outcome predictor: a table of 2-bit saturating counters indexed by PC.
// Predicts at decode, trains on ALU resolve, and pulses mispredict with a
// corrected fetch PC one cycle after a resolve that disagrees with its prediction.
module branch_outcome_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Prediction request from decode
  input  logic                  predict_valid,
  input  logic [ADDR_WIDTH-1:0] predict_addr,
  input  logic [ADDR_WIDTH-1:0] predict_offset,
  output logic                  prediction_valid,
  output logic                  prediction_taken,
  output logic [ADDR_WIDTH-1:0] predicted_target,
  // Resolution from the ALU
  input  logic                  resolve_valid,
  input  logic [ADDR_WIDTH-1:0] resolve_addr,
  input  logic [ADDR_WIDTH-1:0] resolve_target,
  input  logic                  resolve_taken,
  input  logic                  resolve_predicted,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  localparam logic [1:0]  CtrInit = 2'b01;  // weakly not-taken

  logic [1:0]            ctr_q [Entries];
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] res_idx;
  logic [1:0]            pred_ctr;
  logic [1:0]            res_ctr;
  logic [1:0]            res_ctr_next;
  logic                  mismatch;
  logic [ADDR_WIDTH-1:0] redirect_next;
  logic [ADDR_WIDTH-1:0] target_next;

  // Index from word-aligned PC bits; byte offset bits are ignored.
  always_comb begin
    pred_idx = predict_addr[INDEX_BITS+1:2];
    res_idx  = resolve_addr[INDEX_BITS+1:2];
  end

  // Combinational reads; the prediction sees the pre-update value on a same-index collision.
  always_comb begin
    pred_ctr    = ctr_q[pred_idx];
    res_ctr     = ctr_q[res_idx];
    target_next = predict_addr + predict_offset;
  end

  // Saturating counter update.
  always_comb begin
    res_ctr_next = res_ctr;
    if (resolve_taken) begin
      if (res_ctr != 2'b11) res_ctr_next = res_ctr + 2'b01;
    end else begin
      if (res_ctr != 2'b00) res_ctr_next = res_ctr - 2'b01;
    end
  end

  // Mismatch detection and corrected fetch PC.
  always_comb begin
    mismatch      = resolve_valid && (resolve_taken != resolve_predicted);
    redirect_next = resolve_taken ? resolve_target : resolve_addr + ADDR_WIDTH'(4);
  end

  // Counter table storage; single write port driven by the resolve path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i] <= CtrInit;
      end
    end else if (resolve_valid) begin
      ctr_q[res_idx] <= res_ctr_next;
    end
  end

  // Registered prediction outputs; taken/target hold when no request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prediction_valid <= 1'b0;
      prediction_taken <= 1'b0;
      predicted_target <= '0;
    end else begin
      prediction_valid <= predict_valid;
      if (predict_valid) begin
        prediction_taken <= pred_ctr[1];
        predicted_target <= target_next;
      end
    end
  end

  // Registered mispredict pulse; redirect_pc only changes on a mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mismatch;
      if (mismatch) redirect_pc <= redirect_next;
    end
  end

endmodule

// File: tb/tb_branch_outcome_predictor.sv
// Directed, table-driven bench for branch_outcome_predictor.
module tb_branch_outcome_predictor;

  logic        clk;
  logic        rst;
  logic        predict_valid;
  logic [31:0] predict_addr;
  logic [31:0] predict_offset;
  logic        prediction_valid;
  logic        prediction_taken;
  logic [31:0] predicted_target;
  logic        resolve_valid;
  logic [31:0] resolve_addr;
  logic [31:0] resolve_target;
  logic        resolve_taken;
  logic        resolve_predicted;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int checks;
  int errors;

  branch_outcome_predictor #(
    .INDEX_BITS(4),
    .ADDR_WIDTH(32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .predict_valid    (predict_valid),
    .predict_addr     (predict_addr),
    .predict_offset   (predict_offset),
    .prediction_valid (prediction_valid),
    .prediction_taken (prediction_taken),
    .predicted_target (predicted_target),
    .resolve_valid    (resolve_valid),
    .resolve_addr     (resolve_addr),
    .resolve_target   (resolve_target),
    .resolve_taken    (resolve_taken),
    .resolve_predicted(resolve_predicted),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] paddr;
    logic [31:0] poff;
    logic        rv;
    logic [31:0] raddr;
    logic [31:0] rtgt;
    logic        rtaken;
    logic        rpred;
    logic        e_pvalid;
    logic        e_ptaken;
    logic [31:0] e_ptgt;
    logic        e_mp;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " prediction_valid"}, {31'b0, prediction_valid}, {31'b0, v.e_pvalid});
    chk({tag, " prediction_taken"}, {31'b0, prediction_taken}, {31'b0, v.e_ptaken});
    chk({tag, " predicted_target"}, predicted_target, v.e_ptgt);
    chk({tag, " mispredict"}, {31'b0, mispredict}, {31'b0, v.e_mp});
    chk({tag, " redirect_pc"}, redirect_pc, v.e_redir);
  endtask

  task automatic drive(input logic pv, input logic [31:0] paddr, input logic [31:0] poff,
                       input logic rv, input logic [31:0] raddr, input logic [31:0] rtgt,
                       input logic rtaken, input logic rpred);
    predict_valid     = pv;
    predict_addr      = paddr;
    predict_offset    = poff;
    resolve_valid     = rv;
    resolve_addr      = raddr;
    resolve_target    = rtgt;
    resolve_taken     = rtaken;
    resolve_predicted = rpred;
  endtask

  function automatic vec_t mk(logic pv, logic [31:0] paddr, logic [31:0] poff, logic rv,
                              logic [31:0] raddr, logic [31:0] rtgt, logic rtaken,
                              logic rpred, logic e_pvalid, logic e_ptaken,
                              logic [31:0] e_ptgt, logic e_mp, logic [31:0] e_redir);
    vec_t v;
    v.pv = pv; v.paddr = paddr; v.poff = poff; v.rv = rv; v.raddr = raddr;
    v.rtgt = rtgt; v.rtaken = rtaken; v.rpred = rpred; v.e_pvalid = e_pvalid;
    v.e_ptaken = e_ptaken; v.e_ptgt = e_ptgt; v.e_mp = e_mp; v.e_redir = e_redir;
    return v;
  endfunction

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    // Index 0 is shared by 0x100 and 0x200; 0x104/0x144 share index 1; 0xFFFFFFFC is index 15.
    //             pv paddr          poff           rv raddr          rtgt           tk pr  epv ept etgt           emp eredir
    vecs[0]  = mk(1, 32'h100,        32'hFFFFFFF0,  0, 32'h0,         32'h0,         0, 0,  1, 0, 32'h000000F0, 0, 32'h0);
    vecs[1]  = mk(0, 32'h0,          32'h0,         1, 32'h100,       32'h180,       1, 0,  0, 0, 32'h000000F0, 1, 32'h180);
    vecs[2]  = mk(0, 32'h0,          32'h0,         1, 32'h100,       32'h184,       1, 0,  0, 0, 32'h000000F0, 1, 32'h184);
    vecs[3]  = mk(0, 32'h0,          32'h0,         1, 32'h100,       32'h188,       1, 0,  0, 0, 32'h000000F0, 1, 32'h188);
    vecs[4]  = mk(1, 32'h100,        32'h8,         0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h108,      0, 32'h188);
    vecs[5]  = mk(0, 32'h0,          32'h0,         1, 32'h100,       32'h188,       0, 1,  0, 1, 32'h108,      1, 32'h104);
    vecs[6]  = mk(0, 32'h0,          32'h0,         1, 32'h100,       32'h188,       0, 1,  0, 1, 32'h108,      1, 32'h104);
    vecs[7]  = mk(0, 32'h0,          32'h0,         1, 32'h100,       32'h188,       0, 0,  0, 1, 32'h108,      0, 32'h104);
    vecs[8]  = mk(0, 32'h0,          32'h0,         1, 32'h100,       32'h188,       0, 0,  0, 1, 32'h108,      0, 32'h104);
    vecs[9]  = mk(1, 32'h100,        32'h0,         0, 32'h0,         32'h0,         0, 0,  1, 0, 32'h100,      0, 32'h104);
    vecs[10] = mk(0, 32'h0,          32'h0,         1, 32'h200,       32'h300,       1, 0,  0, 0, 32'h100,      1, 32'h300);
    vecs[11] = mk(1, 32'h200,        32'h40,        1, 32'h200,       32'h240,       1, 0,  1, 0, 32'h240,      1, 32'h240);
    vecs[12] = mk(1, 32'h200,        32'h0,         0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h200,      0, 32'h240);
    vecs[13] = mk(0, 32'h0,          32'h0,         1, 32'hFFFFFFFC,  32'h12345678,  0, 1,  0, 1, 32'h200,      1, 32'h0);
    vecs[14] = mk(1, 32'h104,        32'h4,         1, 32'h144,       32'h500,       1, 0,  1, 0, 32'h108,      1, 32'h500);
    vecs[15] = mk(1, 32'h104,        32'h0,         0, 32'h0,         32'h0,         0, 0,  1, 1, 32'h104,      0, 32'h500);
    vecs[16] = mk(1, 32'hFFFFFFFC,   32'h8,         0, 32'h0,         32'h0,         0, 0,  1, 0, 32'h4,        0, 32'h500);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    chk_all("reset", v);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].pv, vecs[i].paddr, vecs[i].poff, vecs[i].rv, vecs[i].raddr,
            vecs[i].rtgt, vecs[i].rtaken, vecs[i].rpred);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted while a mispredict pulse is showing.
    drive(0, 0, 0, 1, 32'h104, 32'h600, 1, 0);
    @(posedge clk);
    #1;
    chk("pre-reset mispredict", {31'b0, mispredict}, 32'h1);
    chk("pre-reset redirect_pc", redirect_pc, 32'h600);
    drive(1, 32'h104, 32'h0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("async reset mispredict", {31'b0, mispredict}, 32'h0);
    chk("async reset redirect_pc", redirect_pc, 32'h0);
    chk("async reset predicted_target", predicted_target, 32'h0);
    @(posedge clk);
    #1;
    chk("held reset prediction_valid", {31'b0, prediction_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Index 1 had been trained to strongly taken; it must now read weakly not-taken.
    drive(1, 32'h144, 32'h0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("post-reset 0x144 taken", {31'b0, prediction_taken}, 32'h0);
    chk("post-reset 0x144 valid", {31'b0, prediction_valid}, 32'h1);
    // Index 0 was at 10 before reset.
    drive(1, 32'h100, 32'h0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("post-reset 0x100 taken", {31'b0, prediction_taken}, 32'h0);
    // One taken resolve from 01 reaches 10 (taken); from 00 it would not.
    drive(0, 0, 0, 1, 32'h108, 32'h700, 1, 1);
    @(posedge clk);
    #1;
    chk("matching resolve no pulse", {31'b0, mispredict}, 32'h0);
    drive(1, 32'h108, 32'h0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("post-reset 0x108 trained taken", {31'b0, prediction_taken}, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("idle prediction_valid low", {31'b0, prediction_valid}, 32'h0);
    chk("idle prediction_taken holds", {31'b0, prediction_taken}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
